// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: EX/MEM control and data into the memory stage,
// load data and forwarded control out toward MEM/WB.
interface mem_access_unit_if;
  logic [1:0]  Size_In;
  logic        Enable_In;
  logic        rw_In;
  logic        Load_In;
  logic        rf_In;
  logic [31:0] Addr_In;
  logic [31:0] Data_In;
  logic [31:0] Data2_In;
  logic        Stall_Out;
  logic [31:0] Data_Out;
  logic        Valid_Out;
  logic        Beat_Out;
  logic        Load_Out;
  logic        rf_Out;
  logic        Align_Err_Out;

  modport master (
    output Size_In, Enable_In, rw_In, Load_In, rf_In,
    output Addr_In, Data_In, Data2_In,
    input  Stall_Out, Data_Out, Valid_Out, Beat_Out,
    input  Load_Out, rf_Out, Align_Err_Out
  );

  modport slave (
    input  Size_In, Enable_In, rw_In, Load_In, rf_In,
    input  Addr_In, Data_In, Data2_In,
    output Stall_Out, Data_Out, Valid_Out, Beat_Out,
    output Load_Out, rf_Out, Align_Err_Out
  );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage access to a big-endian byte RAM.
// Doublewords issue as two word beats, stalling upstream one cycle.
module mem_access_unit #(
  parameter int ADDR_W = 8
) (
  input logic            CLK,
  input logic            CLR,
  mem_access_unit_if.slave bus
);

  typedef enum logic {IDLE, DW2} state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  logic [7:0] mem [2**ADDR_W];

  state_t            state;
  logic [ADDR_W-1:0] addr2;
  logic [31:0]       data2;
  logic              rw2;
  logic              load2;
  logic              rf2;

  logic [31:0] data_q;
  logic        valid_q;
  logic        beat_q;
  logic        load_q;
  logic        rf_q;
  logic        err_q;

  logic [ADDR_W-1:0] a_in;
  logic              is_idle;
  logic              aligned;
  logic              acc;
  logic              we;
  logic [ADDR_W-1:0] p0, p1, p2, p3;
  logic [1:0]        asz;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              unused_addr;

  assign a_in    = bus.Addr_In[ADDR_W-1:0];
  assign is_idle = (state == IDLE);
  assign unused_addr = ^bus.Addr_In[31:ADDR_W];

  // Alignment rule per access size.
  always_comb begin
    aligned = 1'b0;
    unique case (1'b1)
      (bus.Size_In == SZ_B): aligned = 1'b1;
      (bus.Size_In == SZ_H): aligned = ~a_in[0];
      default:               aligned = (a_in[1:0] == 2'b00);
    endcase
  end

  assign acc = is_idle & bus.Enable_In & aligned;
  assign we  = CLR & ((acc & bus.rw_In) | (~is_idle & rw2));

  assign bus.Stall_Out = CLR & acc & (bus.Size_In == SZ_D);

  // Select the beat being issued: live request or latched second word.
  always_comb begin
    p0    = is_idle ? a_in : addr2;
    asz   = (is_idle && bus.Size_In != SZ_D) ? bus.Size_In : SZ_W;
    wdata = is_idle ? bus.Data_In : data2;
  end

  assign p1 = p0 + ADDR_W'(1);
  assign p2 = p0 + ADDR_W'(2);
  assign p3 = p0 + ADDR_W'(3);

  // Big-endian read, zero-extended for narrow sizes.
  always_comb begin
    rdata = 32'd0;
    unique case (1'b1)
      (asz == SZ_B): rdata = {24'd0, mem[p0]};
      (asz == SZ_H): rdata = {16'd0, mem[p0], mem[p1]};
      default:       rdata = {mem[p0], mem[p1], mem[p2], mem[p3]};
    endcase
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (we) begin
      unique case (1'b1)
        (asz == SZ_B): mem[p0] <= wdata[7:0];
        (asz == SZ_H): begin
          mem[p0] <= wdata[15:8];
          mem[p1] <= wdata[7:0];
        end
        default: begin
          mem[p0] <= wdata[31:24];
          mem[p1] <= wdata[23:16];
          mem[p2] <= wdata[15:8];
          mem[p3] <= wdata[7:0];
        end
      endcase
    end
  end

  // Sequencer and registered outputs toward MEM/WB.
  always_ff @(posedge CLK) begin
    if (!CLR) begin
      state   <= IDLE;
      addr2   <= '0;
      data2   <= 32'd0;
      rw2     <= 1'b0;
      load2   <= 1'b0;
      rf2     <= 1'b0;
      data_q  <= 32'd0;
      valid_q <= 1'b0;
      beat_q  <= 1'b0;
      load_q  <= 1'b0;
      rf_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          beat_q  <= 1'b0;
          load_q  <= bus.Load_In;
          rf_q    <= bus.rf_In;
          err_q   <= 1'b0;
          valid_q <= 1'b0;
          data_q  <= 32'd0;
          if (bus.Enable_In && !aligned) begin
            err_q <= 1'b1;
            rf_q  <= 1'b0;
          end else if (acc) begin
            if (!bus.rw_In) begin
              valid_q <= 1'b1;
              data_q  <= rdata;
            end
            if (bus.Size_In == SZ_D) begin
              addr2 <= a_in + ADDR_W'(4);
              data2 <= bus.Data2_In;
              rw2   <= bus.rw_In;
              load2 <= bus.Load_In;
              rf2   <= bus.rf_In;
              state <= DW2;
            end
          end
        end
        DW2: begin
          beat_q  <= 1'b1;
          load_q  <= load2;
          rf_q    <= rf2;
          err_q   <= 1'b0;
          valid_q <= ~rw2;
          data_q  <= rw2 ? 32'd0 : rdata;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Data_Out      = data_q;
  assign bus.Valid_Out     = valid_q;
  assign bus.Beat_Out      = beat_q;
  assign bus.Load_Out      = load_q;
  assign bus.rf_Out        = rf_q;
  assign bus.Align_Err_Out = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed accesses checked
// against a byte-array model of the data RAM.
module tb_mem_access_unit;

  logic CLK;
  logic CLR;

  mem_access_unit_if bus();

  mem_access_unit #(.ADDR_W(8)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] ref_mem [256];
  int n_chk;
  int n_pass;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = ref_mem[a];
    b1 = ref_mem[a + 8'd1];
    b2 = ref_mem[a + 8'd2];
    b3 = ref_mem[a + 8'd3];
    if (sz == 2'd0) return {24'd0, b0};
    if (sz == 2'd1) return {16'd0, b0, b1};
    return {b0, b1, b2, b3};
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [7:0] a,
                         input logic [31:0] d);
    if (sz == 2'd0) begin
      ref_mem[a] = d[7:0];
    end else if (sz == 2'd1) begin
      ref_mem[a]        = d[15:8];
      ref_mem[a + 8'd1] = d[7:0];
    end else begin
      ref_mem[a]        = d[31:24];
      ref_mem[a + 8'd1] = d[23:16];
      ref_mem[a + 8'd2] = d[15:8];
      ref_mem[a + 8'd3] = d[7:0];
    end
  endtask

  task automatic drive(input logic [1:0] sz, input logic en,
                       input logic rw, input logic ld, input logic rf,
                       input logic [31:0] ad, input logic [31:0] d1,
                       input logic [31:0] d2);
    bus.Size_In   = sz;
    bus.Enable_In = en;
    bus.rw_In     = rw;
    bus.Load_In   = ld;
    bus.rf_In     = rf;
    bus.Addr_In   = ad;
    bus.Data_In   = d1;
    bus.Data2_In  = d2;
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_data"}, bus.Data_Out, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.Valid_Out}, 32'd0);
    chk({tag, "_beat"}, {31'd0, bus.Beat_Out}, 32'd0);
    chk({tag, "_load"}, {31'd0, bus.Load_Out}, 32'd0);
    chk({tag, "_rf"}, {31'd0, bus.rf_Out}, 32'd0);
    chk({tag, "_err"}, {31'd0, bus.Align_Err_Out}, 32'd0);
  endtask

  // One request; kill=1 pulls reset during the second doubleword beat.
  task automatic op(input logic [1:0] sz, input logic en,
                    input logic rw, input logic ld, input logic rf,
                    input logic [31:0] ad, input logic [31:0] d1,
                    input logic [31:0] d2, input logic kill);
    logic [7:0]  a;
    logic        al;
    logic        ok;
    logic        dw;
    logic [1:0]  wsz;
    logic [31:0] e1;
    logic [31:0] e2;
    a   = ad[7:0];
    al  = (sz == 2'd0) || (sz == 2'd1 && !a[0]) || (a[1:0] == 2'd0);
    ok  = en && al;
    dw  = ok && (sz == 2'd3);
    wsz = (sz == 2'd3) ? 2'd2 : sz;
    drive(sz, en, rw, ld, rf, ad, d1, d2);
    #1;
    chk("stall", {31'd0, bus.Stall_Out}, {31'd0, dw});
    e1 = 32'd0;
    if (ok) begin
      if (rw) m_store(wsz, a, d1);
      else e1 = m_load(wsz, a);
    end
    @(posedge CLK);
    #1;
    chk("valid", {31'd0, bus.Valid_Out}, {31'd0, ok && !rw});
    chk("data", bus.Data_Out, e1);
    chk("beat", {31'd0, bus.Beat_Out}, 32'd0);
    chk("load", {31'd0, bus.Load_Out}, {31'd0, ld});
    chk("rf", {31'd0, bus.rf_Out}, {31'd0, rf && !(en && !al)});
    chk("err", {31'd0, bus.Align_Err_Out}, {31'd0, en && !al});
    if (dw) begin
      drive(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom, $urandom, $urandom);
      if (kill) CLR = 1'b0;
      #1;
      chk("stall2", {31'd0, bus.Stall_Out}, 32'd0);
      e2 = 32'd0;
      if (!kill) begin
        if (rw) m_store(2'd2, a + 8'd4, d2);
        else e2 = m_load(2'd2, a + 8'd4);
      end
      @(posedge CLK);
      #1;
      if (kill) begin
        chk_idle_outs("kill");
        CLR = 1'b1;
      end else begin
        chk("valid2", {31'd0, bus.Valid_Out}, {31'd0, !rw});
        chk("data2", bus.Data_Out, e2);
        chk("load2", {31'd0, bus.Load_Out}, {31'd0, ld});
        chk("rf2", {31'd0, bus.rf_Out}, {31'd0, rf});
        if (!rw) chk("beat2", {31'd0, bus.Beat_Out}, 32'd1);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    CLR    = 1'b0;
    drive(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_stall", {31'd0, bus.Stall_Out}, 32'd0);
    chk_idle_outs("rst");
    CLR = 1'b1;

    for (int i = 0; i < 64; i++)
      op(2'd2, 1'b1, 1'b1, 1'b0, 1'b0,
         {$urandom_range(255, 0), 24'd0} | 32'(i * 4),
         $urandom, 32'd0, 1'b0);

    op(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      op(2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10 + 32'(i), 0, 0, 1'b0);
    op(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h12, 32'hFFFF1234, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 0, 0, 1'b0);
    op(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h11111111,
       32'h22222222, 1'b0);
    op(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 0, 0, 1'b0);
    op(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFC, 32'hA5A5A5A5,
       32'h5A5A5A5A, 1'b0);
    op(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h7FC, 0, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h02, 0, 0, 1'b0);
    op(2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'h02, 32'hCAFEF00D, 0, 1'b0);
    op(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h03, 32'hCAFEF00D, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 0, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h04, 0, 0, 1'b0);
    op(2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0BADBEEF, 0, 1'b0);
    op(2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 0, 0, 1'b0);
    op(2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h77777777,
       32'h88888888, 1'b1);
    op(2'd3, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 0, 0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ad;
      ad = $urandom;
      if ($urandom_range(3, 0) != 0) ad[1:0] = 2'b00;
      op(2'($urandom), ($urandom_range(9, 0) != 0), 1'($urandom),
         1'($urandom), 1'($urandom), ad, $urandom, $urandom,
         ($urandom_range(19, 0) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data access unit sitting directly downstream of the EX/MEM pipeline register. It consumes the registered memory controls (Size, Enable, rw, Load, rf) plus address and store data, performs byte/halfword/word/doubleword accesses on an internal big-endian byte-addressed data RAM, and presents load data and forwarded control to the MEM/WB register. Doubleword accesses take two beats and stall the upstream pipeline for one cycle.

## Interface
- ADDR_W, 8, RAM address width in bits; RAM holds 2^ADDR_W bytes
- CLK  input  1  clock, all state updates on rising edge
- CLR  input  1  synchronous, active-low reset (CLR=0 resets on next rising edge of CLK)
- Size_In  input  2  00 byte, 01 halfword, 10 word, 11 doubleword
- Enable_In  input  1  1 = memory access requested this cycle
- rw_In  input  1  1 = write (store), 0 = read (load)
- Load_In  input  1  load-select for WB mux, forwarded
- rf_In  input  1  register-file write enable, forwarded
- Addr_In  input  32  byte address; only Addr_In[ADDR_W-1:0] used
- Data_In  input  32  store data, first/only word
- Data2_In  input  32  store data, second word (doubleword only)
- Stall_Out  output  1  1 = upstream must hold EX/MEM contents this cycle
- Data_Out  output  32  load data, zero-extended for byte/halfword
- Valid_Out  output  1  1 = Data_Out holds a completed load beat
- Beat_Out  output  1  0 = first word, 1 = second word of doubleword
- Load_Out  output  1  registered Load_In
- rf_Out  output  1  registered rf_In
- Align_Err_Out  output  1  1-cycle pulse: misaligned access rejected

## Operation
- FSM states: IDLE, DW2. Reset state IDLE.
- IDLE, Enable_In=0: no RAM access; Load_Out/rf_Out register inputs; Valid_Out=0, Beat_Out=0, Data_Out=0.
- IDLE, Enable_In=1, aligned, Size!=11: single access; read -> Data_Out, Valid_Out=1 next cycle; write -> RAM updated at edge, Valid_Out=0.
- IDLE, Enable_In=1, aligned, Size=11: first word at A, latch A+4 and Data2_In; go DW2. DW2: second word at A+4 (mod 2^ADDR_W), return to IDLE.
- Alignment: halfword needs A[0]=0; word/doubleword need A[1:0]=00. Misaligned: no RAM write, Align_Err_Out=1, Valid_Out=0, rf_Out forced 0, Data_Out=0, stays IDLE.
- Big-endian: byte at A is bits [31:24] of word; halfword = {mem[A],mem[A+1]}; byte/halfword stores update only addressed bytes, using Data_In low bits.
- Byte load zero-extends to 32 bits; halfword likewise.
- Address arithmetic modulo 2^ADDR_W; upper Addr_In bits ignored.
- Inputs ignored in DW2 (upstream held by Stall_Out); second beat uses latched address/data/rw/Load/rf.
- RAM contents not affected by reset.

## Timing
- Stall_Out combinational: 1 in cycle of accepting a doubleword (IDLE, Enable_In=1, Size=11, aligned) and 0 otherwise (including DW2 cycle, so upstream advances after second beat is issued).
- Single load: request at edge N -> Data_Out/Valid_Out valid after edge N+1, held one cycle.
- Doubleword load: word0 after edge N+1 (Beat_Out=0), word1 after edge N+2 (Beat_Out=1); Valid_Out high both cycles; rf_Out/Load_Out present on both beats.
- Store: RAM write at edge N (byte/half/word); doubleword writes A at N, A+4 at N+1.
- Load after store to same address, back-to-back: returns new data.
- Reset values: state IDLE, Stall_Out=0, Data_Out=0, Valid_Out=0, Beat_Out=0, Load_Out=0, rf_Out=0, Align_Err_Out=0.
- CLR=0 during DW2: second beat abandoned (no write to A+4, no Valid_Out), FSM to IDLE.

## Test plan
- Word store 0xDEADBEEF at 0x10, then word load 0x10 -> Data_Out=0xDEADBEEF, Valid_Out=1 one cycle after load request, rf_Out mirrors rf_In.
- Byte loads at 0x10..0x13 after above -> 0x000000DE, 0x000000AD, 0x000000BE, 0x000000EF; halfword store 0x1234 at 0x12 then word load 0x10 -> 0xDEAD1234.
- Doubleword store {0x11111111,0x22222222} at 0x20 -> Stall_Out=1 for one cycle; doubleword load 0x20 -> beats 0x11111111 (Beat_Out=0), 0x22222222 (Beat_Out=1) on consecutive cycles.
- Doubleword at 0xFC with ADDR_W=8 -> second word at 0x00 (wrap); word load at 0x02 -> Align_Err_Out=1, Valid_Out=0, rf_Out=0, RAM unchanged.
- Enable_In=0 with rf_In=1, Load_In=0 -> rf_Out=1, Load_Out=0, Valid_Out=0 next cycle, no RAM change.
- CLR=0 asserted in DW2 of doubleword store -> word at A+4 unchanged, all outputs at reset values next cycle, FSM IDLE.
